// File: rtl/fetch_ifid_ctrl_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and imem (slave).
interface fetch_ifid_ctrl_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 16
);
   logic [PC_W-1:0]    addr;
   logic               req;
   logic [INSTR_W-1:0] instr;
   logic               ready;

   modport master (output addr, output req, input instr, input ready);
   modport slave  (input addr, input req, output instr, output ready);
endinterface

// File: rtl/fetch_ifid_ctrl.sv
// Fetch stage plus IF/ID register: owns the PC, issues imem fetches, applies
// redirect/wipe/stall, and stops fetch once a speculatively seen HALT can no
// longer be squashed.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   RUN       | normal fetch; PC advances on every accepted instruction
//   HALT_PEND | HALT is in IF/ID; fetch data ignored while it may be squashed
//   HALTED    | HALT committed; PC and IF/ID frozen until reset
module fetch_ifid_ctrl #(
   parameter int               PC_W      = 16,
   parameter int               INSTR_W   = 16,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800,
   parameter logic [PC_W-1:0]  RESET_PC  = 16'h0000,
   parameter int               HALT_WIN  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               wipe,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   fetch_ifid_ctrl_if.master  imem,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc2,
   output logic               ifid_valid,
   output logic               halted
);

   localparam int CNT_W = (HALT_WIN > 2) ? $clog2(HALT_WIN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_WIN - 1);

   typedef enum logic [1:0] {
      RUN       = 2'b00,
      HALT_PEND = 2'b01,
      HALTED    = 2'b10
   } state_t;

   state_t           state;
   logic [PC_W-1:0]  pc;
   logic [CNT_W-1:0] cnt;
   logic [PC_W-1:0]  pc_next_seq;
   logic             is_halt;

   assign pc_next_seq = pc + PC_W'(2);
   assign is_halt     = (imem.instr[INSTR_W-1 -: 5] == 5'b00000);

   assign imem.addr = pc;
   assign imem.req  = (state != HALTED);

   // Fetch sequencing: PC, IF/ID register, halt window and halted flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         cnt        <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_pc2   <= '0;
         ifid_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (redirect) begin
                  pc         <= redirect_pc;
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
               end else if (wipe) begin
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
               end else if (stall) begin
                  ifid_valid <= ifid_valid;
               end else if (!imem.ready) begin
                  ifid_instr <= NOP_INSTR;
                  ifid_valid <= 1'b0;
               end else begin
                  ifid_instr <= imem.instr;
                  ifid_pc2   <= pc_next_seq;
                  ifid_valid <= 1'b1;
                  if (is_halt) begin
                     // PC parks on the HALT so a squash can replay from here.
                     state <= HALT_PEND;
                     cnt   <= '0;
                  end else begin
                     pc <= pc_next_seq;
                  end
               end
            end
            HALT_PEND: begin
               ifid_instr <= NOP_INSTR;
               ifid_valid <= 1'b0;
               cnt        <= cnt + CNT_W'(1);
               if (redirect) begin
                  pc    <= redirect_pc;
                  cnt   <= '0;
                  state <= RUN;
               end else if (cnt == CNT_LAST) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end
            end
            HALTED: begin
               halted <= 1'b1;
            end
            default: begin
               // Unreachable encoding: fall back to normal fetch.
               state <= RUN;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
